// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - segment glyphs, FSM encoding and defaults for the seven-segment scan monitor
package seg_scan_pkg;

   localparam int DEFAULT_NUM_DIGITS = 6;

   // Active-low glyphs with the decimal point bit held at 1 (dp off)
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_B     = 8'h83;
   localparam logic [7:0] SEG_C     = 8'hC6;
   localparam logic [7:0] SEG_D     = 8'hA1;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_7_ALT = 8'hD8;
   localparam logic [7:0] SEG_9_ALT = 8'h98;

   // Capture FSM encoding
   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HELD   = 2'd2;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low seven-segment to hex nibble decoder
module seg7_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       valid
);

   // Match the pattern with the dp bit forced off against the glyph table
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b1;
      case ({1'b1, seg})
         SEG_0:            nibble = 4'h0;
         SEG_1:            nibble = 4'h1;
         SEG_2:            nibble = 4'h2;
         SEG_3:            nibble = 4'h3;
         SEG_4:            nibble = 4'h4;
         SEG_5:            nibble = 4'h5;
         SEG_6:            nibble = 4'h6;
         SEG_7, SEG_7_ALT: nibble = 4'h7;
         SEG_8:            nibble = 4'h8;
         SEG_9, SEG_9_ALT: nibble = 4'h9;
         SEG_A:            nibble = 4'hA;
         SEG_B:            nibble = 4'hB;
         SEG_C:            nibble = 4'hC;
         SEG_D:            nibble = 4'hD;
         SEG_E:            nibble = 4'hE;
         SEG_F:            nibble = 4'hF;
         default:          valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - rebuilds hex digits and dps from a multiplexed 7-seg drive; SCAN_TIMEOUT_EN adds frame_stale
module seg_scan_capture
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 4096
)(
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [7:0]              DISP_Seg,
   input  logic [NUM_DIGITS-1:0]   AN,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dps,
   output logic                    frame_valid,
   output logic                    frame_changed,
   output logic                    seg_err,
   output logic                    an_err,
   output logic                    frame_stale
);

   localparam bit PARAMS_OK = (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 255) &&
                              (TIMEOUT_CYCLES >= 1) && (NUM_DIGITS >= 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   if (!PARAMS_OK) begin : g_bad_params
      $error("seg_scan_capture: parameter out of range");
   end

   logic [NUM_DIGITS-1:0]   prev_an;
   logic [7:0]              prev_seg;
   logic [1:0]              state;
   logic [7:0]              settle_cnt;
   logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
   logic [NUM_DIGITS-1:0]   dps_shadow, dps_nxt;
   logic [NUM_DIGITS-1:0]   seen, seen_base, seen_nxt;
   logic [NUM_DIGITS-1:0]   an_low;
   logic                    change, sample, an_one_hot, complete, stale;
   logic [3:0]              dec_nibble;
   logic                    dec_valid;

   seg7_decode u_decode (
      .seg    (DISP_Seg[6:0]),
      .nibble (dec_nibble),
      .valid  (dec_valid)
   );

   assign an_low     = ~AN;
   assign an_one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
   assign change     = (AN != prev_an) || (DISP_Seg != prev_seg);
   assign sample     = (state == ST_SETTLE) && !change && (settle_cnt == SETTLE_LAST);

`ifdef SCAN_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

   logic [IDLE_W-1:0] idle_cnt;

   // Idle counter: restarts on every sample, saturates at the timeout
   always_ff @(posedge Clock) begin
      if (Reset)
         idle_cnt <= '0;
      else if (sample)
         idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
         idle_cnt <= idle_cnt + 1'b1;
   end

   assign stale       = (idle_cnt == IDLE_MAX);
   assign frame_stale = stale;
`else
   assign stale       = 1'b0;
   assign frame_stale = 1'b0;
`endif

   // A stall drops partially collected digits so a frame never spans it
   assign seen_base = stale ? '0 : seen;

   // Merge the digit being sampled into the shadow frame
   always_comb begin
      shadow_nxt = shadow;
      dps_nxt    = dps_shadow;
      seen_nxt   = seen_base;
      if (sample && an_one_hot) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) begin
               shadow_nxt[4*i +: 4] = dec_valid ? dec_nibble : 4'h0;
               dps_nxt[i]           = ~DISP_Seg[7];
               seen_nxt[i]          = 1'b1;
            end
         end
      end
   end

   assign complete = sample && an_one_hot && (&seen_nxt);

   // Input history and settle FSM; history resets to a blank display
   always_ff @(posedge Clock) begin
      if (Reset) begin
         prev_an    <= '1;
         prev_seg   <= 8'hFF;
         state      <= ST_WAIT;
         settle_cnt <= 8'd0;
      end else begin
         prev_an  <= AN;
         prev_seg <= DISP_Seg;
         case (state)
            ST_WAIT: begin
               if (change) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= 8'd0;
               end
            end
            ST_SETTLE: begin
               if (change)
                  settle_cnt <= 8'd0;
               else if (settle_cnt == SETTLE_LAST)
                  state <= ST_HELD;
               else
                  settle_cnt <= settle_cnt + 8'd1;
            end
            ST_HELD: begin
               if (change) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= 8'd0;
               end
            end
            default: begin
               state      <= ST_WAIT;
               settle_cnt <= 8'd0;
            end
         endcase
      end
   end

   // Shadow frame, published frame, pulses and sticky error flags
   always_ff @(posedge Clock) begin
      if (Reset) begin
         shadow        <= '0;
         dps_shadow    <= '0;
         seen          <= '0;
         digits        <= '0;
         dps           <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         seg_err       <= 1'b0;
         an_err        <= 1'b0;
      end else begin
         shadow        <= shadow_nxt;
         dps_shadow    <= dps_nxt;
         frame_valid   <= complete;
         frame_changed <= complete && ({shadow_nxt, dps_nxt} != {digits, dps});
         if (complete) begin
            digits <= shadow_nxt;
            dps    <= dps_nxt;
            seen   <= '0;
         end else begin
            seen   <= seen_nxt;
         end
         if (sample && !an_one_hot)
            an_err <= 1'b1;
         if (sample && an_one_hot && !dec_valid)
            seg_err <= 1'b1;
      end
   end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Monitor that receives the multiplexed 6-digit seven-segment drive (DISP_Seg/AN) produced by the SOC display scanner.
- Reconstructs the 24-bit hex value and the decimal points actually being shown; it is the decoder end of the display-encoder path.
- Sits beside the SOC in simulation and on-board self-check, so displayed values are compared against Test_signal without manual inspection.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (AN width; digits output = 4*NUM_DIGITS bits).
- SETTLE_CYCLES, 4, cycles AN and DISP_Seg must be unchanged before a digit is sampled (ghosting rejection); legal range 1..255.
- TIMEOUT_CYCLES, 4096, idle cycles without a completed digit sample before frame_stale asserts (only with SCAN_TIMEOUT_EN).

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- DISP_Seg  in  8  segment drive, active-low; bit0=a … bit6=g, bit7=dp.
- AN  in  NUM_DIGITS  digit enables, active-low, one-hot-low when valid.
- digits  out  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i].
- dps  out  NUM_DIGITS  decimal point per digit of last frame (1 = lit).
- frame_valid  out  1  one-cycle pulse when digits/dps update.
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when the new digits/dps differ from the previous frame.
- seg_err  out  1  sticky: a settled digit had a non-hex segment pattern.
- an_err  out  1  sticky: AN settled with zero or multiple low bits.
- frame_stale  out  1  level: no digit captured for TIMEOUT_CYCLES (tied 0 without SCAN_TIMEOUT_EN).

Behaviour:
- Reset: digits=0, dps=0, frame_valid=0, frame_changed=0, seg_err=0, an_err=0, frame_stale=0; shadow regs, seen mask and counters cleared; FSM→WAIT.
- Registers: previous AN/DISP_Seg for change detection; settle counter (8 bits); shadow digits/dps; seen mask (NUM_DIGITS bits).
- FSM states WAIT, SETTLE, HELD.
  - WAIT→SETTLE on any AN or DISP_Seg change.
  - SETTLE: counter increments while inputs are unchanged. Any change restarts the counter at 0 and stays in SETTLE. When counter==SETTLE_CYCLES-1 with no change, sample and go to HELD.
  - HELD: no further samples until the next input change, which moves the FSM →SETTLE with counter 0.
- Sample action:
  - If AN is not one-hot-low: set an_err; discard the sample.
  - Otherwise for index i: shadow[i] ← decoded nibble, dps_shadow[i] ← ~DISP_Seg[7], seen[i] ← 1.
  - If the pattern is invalid: set seg_err, write nibble 0, still mark seen.
- Completion:
  - In the cycle the sample makes seen all-ones, the next edge copies shadow → digits/dps (including the digit just sampled), pulses frame_valid, and clears seen.
  - frame_changed compares against the prior digits/dps; the first frame after reset always compares against 0.
- Re-sampling an already-seen digit before the frame completes overwrites its shadow entry; the newest value wins.
- Latency: output updates SETTLE_CYCLES+1 cycles after the last digit's inputs become stable.
- Decode table (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E, evaluated with bit7 masked to 1. 7=D8 and 9=98 are also accepted as alternate glyphs.
- Error flags clear only on Reset.
- Reset mid-frame discards the shadow regs and seen mask; no frame_valid is generated.

Optional Feature:
- SCAN_TIMEOUT_EN defined:
  - An idle counter resets on every sample and saturates at TIMEOUT_CYCLES.
  - frame_stale=1 while saturated; cleared on the next sample.
  - seen is cleared on timeout, so a frame never spans a stall.
- Undefined: no idle counter; frame_stale is constant 0.

Decomposition:
- Package seg_scan_pkg holds:
  - segment pattern localparams SEG_0..SEG_F and alternate glyphs;
  - the FSM state encoding (WAIT/SETTLE/HELD);
  - the default NUM_DIGITS.
- Sub-module seg7_decode is combinational: 7-bit pattern in → nibble + valid out. It is instantiated once on the current DISP_Seg.

Test Plan:
- Scan 1,2,3,4,5,A (DISP_Seg F9,A4,B0,99,92,88 on AN 3E,3D,3B,37,2F,1F), 8 cycles each → digits=24'hA54321, dps=0, one frame_valid and frame_changed after the 6th digit settles.
- Repeat the identical scan → frame_valid pulses, frame_changed stays 0; then the same scan with digit 0 = 7F (dp-only, invalid) → seg_err=1, digits[3:0]=0.
- Glitch: drive AN=3E for 2 cycles, then 3D (SETTLE_CYCLES=4) → no sample for digit 0; seen reflects only digit 1.
- AN=3C (two digits low), stable for 8 cycles → an_err=1, no seen bit set; Reset → an_err=0, all outputs 0.
- Reset asserted after 3 of 6 digits sampled → no frame_valid; a following full scan of C0 ×6 → digits=0, frame_valid, frame_changed=0.
- SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=64: hold inputs constant for 70 cycles → frame_stale=1 from cycle 64; the next sample clears it.
